cmp_match_sched: RTL and testbench

- Scheduler/controller for the 16-stage synchronous counter-comparator datapath (count-enable input P_0, 17-bit compare bus C_0..C_16, match output Z).
- Arbitrates that single datapath between NREQ requesters, round-robin. Each request supplies a compare word.
- Drives the compare bus and pulses count-enable until Z reports a match, a timeout expires, or an abort arrives.
- Returns one response per request with status and elapsed enable cycles.

---
 rtl/cmp_match_sched_if.sv | 31 +++
 rtl/cmp_match_sched.sv | 164 ++++++++++++++++
 tb/tb_cmp_match_sched.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_match_sched_if.sv
// Request, datapath and response signals of the counter-comparator scheduler.
// The scheduler uses the slave view; the requester/datapath side uses master.
interface cmp_match_sched_if #(
  parameter int NREQ = 2,
  parameter int CW   = 17,
  parameter int TOW  = 16
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*CW-1:0] req_cmp;
  logic [NREQ-1:0]    req_ready;
  logic               abort;
  logic               p_0;
  logic [CW-1:0]      c_out;
  logic               z_in;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2:0]         rsp_id;
  logic               rsp_hit;
  logic               rsp_abort;
  logic [TOW-1:0]     rsp_count;

  modport slave (
    input  req_valid, req_cmp, abort, z_in, rsp_ready,
    output req_ready, p_0, c_out, rsp_valid, rsp_id, rsp_hit, rsp_abort, rsp_count
  );

  modport master (
    output req_valid, req_cmp, abort, z_in, rsp_ready,
    input  req_ready, p_0, c_out, rsp_valid, rsp_id, rsp_hit, rsp_abort, rsp_count
  );
endinterface

// File: rtl/cmp_match_sched.sv
// Round-robin scheduler that shares one counter-comparator datapath between
// NREQ requesters and reports hit / abort / timeout with elapsed run cycles.
//
// state | meaning
// IDLE  | waiting for any request; picks next requester at/after the pointer
// GRANT | one-cycle accept pulse to the chosen requester
// LOAD  | compare word on the bus, count enable off while the compare settles
// RUN   | count enable on until match, abort or timeout
// RESP  | response held until accepted
module cmp_match_sched #(
  parameter int NREQ    = 2,
  parameter int CW      = 17,
  parameter int TOW     = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             ck,
  input  logic             rst_n,
  cmp_match_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]     state;
  logic [2:0]     ptr;
  logic [2:0]     id;
  logic [CW-1:0]  cmp_lat;
  logic [TOW-1:0] cnt;
  logic [TOW-1:0] cnt_inc;

  logic           p_0;
  logic [CW-1:0]  c_out;
  logic           rsp_valid;
  logic [2:0]     rsp_id;
  logic           rsp_hit;
  logic           rsp_abort;
  logic [TOW-1:0] rsp_count;
  logic [NREQ-1:0] req_ready;

  logic           req_any;
  logic           hi_found;
  logic [2:0]     hi_id;
  logic [2:0]     lo_id;
  logic [2:0]     pick;
  logic [CW-1:0]  pick_cmp;
  logic           early_abort;
  logic           run_done;

  // Lowest valid index at or above the pointer wins; otherwise wrap to the
  // lowest valid index overall.
  always_comb begin
    req_any  = 1'b0;
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        req_any = 1'b1;
        lo_id   = 3'(i);
        if (3'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_id    = 3'(i);
        end
      end
    end
    pick = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    pick_cmp = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 3'(i)) pick_cmp = bus.req_cmp[i*CW +: CW];
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state == S_GRANT) && (id == 3'(i));
    end
  end

  assign cnt_inc     = cnt + TOW'(1);
  assign early_abort = bus.abort && ((state == S_GRANT) || (state == S_LOAD));
  // Match outranks abort, which outranks timeout; all three end the run.
  assign run_done    = bus.z_in || bus.abort || (cnt_inc == TOW'(TIMEOUT));

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      id        <= '0;
      cmp_lat   <= '0;
      cnt       <= '0;
      p_0       <= 1'b0;
      c_out     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_hit   <= 1'b0;
      rsp_abort <= 1'b0;
      rsp_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            id      <= pick;
            cmp_lat <= pick_cmp;
            state   <= S_GRANT;
          end
        end
        S_GRANT, S_LOAD: begin
          if (state == S_GRANT) c_out <= cmp_lat;
          cnt <= '0;
          if (early_abort) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= id;
            rsp_hit   <= 1'b0;
            rsp_abort <= 1'b1;
            rsp_count <= '0;
          end else if (state == S_GRANT) begin
            state <= S_LOAD;
          end else begin
            state <= S_RUN;
            p_0   <= 1'b1;
          end
        end
        S_RUN: begin
          cnt <= cnt_inc;
          if (run_done) begin
            state     <= S_RESP;
            p_0       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= id;
            rsp_hit   <= bus.z_in;
            rsp_abort <= !bus.z_in && bus.abort;
            rsp_count <= cnt_inc;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
            ptr       <= (id == 3'(NREQ - 1)) ? 3'd0 : id + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.p_0       = p_0;
  assign bus.c_out     = c_out;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_hit   = rsp_hit;
  assign bus.rsp_abort = rsp_abort;
  assign bus.rsp_count = rsp_count;

endmodule

// File: tb/tb_cmp_match_sched.sv
// Directed bench for cmp_match_sched: transaction model of round-robin choice
// and run outcome, checked every cycle, plus literal pins on key results.
module tb_cmp_match_sched;
  localparam int NREQ    = 2;
  localparam int CW      = 17;
  localparam int TOW     = 16;
  localparam int TIMEOUT = 1000;

  typedef struct {
    int            id;
    bit            hit;
    bit            ab;
    int            count;
    logic [CW-1:0] cmp;
  } exp_t;

  logic ck = 1'b0;
  logic rst_n = 1'b0;

  cmp_match_sched_if #(.NREQ(NREQ), .CW(CW), .TOW(TOW)) bus ();

  cmp_match_sched #(.NREQ(NREQ), .CW(CW), .TOW(TOW), .TIMEOUT(TIMEOUT)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 ck = ~ck;

  int n_vec = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  exp_t ce;
  logic [CW-1:0] cmp_w [NREQ];
  int m_ptr = 0;

  int p_high = 0;
  int grants = 0;
  bit prev_rv = 1'b0;
  int cap_id, cap_hit, cap_ab, cap_count, cap_phigh, cap_cout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, want, want, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_word(input int i, input logic [CW-1:0] w);
    cmp_w[i] = w;
    for (int k = 0; k < NREQ; k++) bus.req_cmp[k*CW +: CW] = cmp_w[k];
  endtask

  // Per-cycle compare against the front expected transaction.
  always @(posedge ck) begin
    #2;
    if (!rst_n) begin
      chk("rst_p0", 32'(bus.p_0), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_hit", 32'(bus.rsp_hit), 32'd0);
      chk("rst_abort", 32'(bus.rsp_abort), 32'd0);
      chk("rst_c_out", 32'(bus.c_out), 32'd0);
      chk("rst_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_count", 32'(bus.rsp_count), 32'd0);
      p_high  = 0;
      grants  = 0;
      prev_rv = 1'b0;
    end else if (exp_q.size() == 0) begin
      chk("idle_p0", 32'(bus.p_0), 32'd0);
      chk("idle_ready", 32'(bus.req_ready), 32'd0);
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      prev_rv = 1'b0;
    end else begin
      ce = exp_q[0];
      if (bus.req_ready != '0) begin
        grants++;
        chk("grant_onehot", 32'(bus.req_ready), 32'd1 << ce.id);
      end
      if (bus.p_0) begin
        p_high++;
        chk("c_out_run", 32'(bus.c_out), 32'(ce.cmp));
      end
      if (bus.rsp_valid) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(ce.id));
        chk("rsp_hit", 32'(bus.rsp_hit), 32'(ce.hit));
        chk("rsp_abort", 32'(bus.rsp_abort), 32'(ce.ab));
        chk("rsp_count", 32'(bus.rsp_count), 32'(ce.count));
        chk("resp_p0_low", 32'(bus.p_0), 32'd0);
        if (!prev_rv) begin
          chk("p0_cycles", 32'(p_high), 32'(ce.count));
          cap_id    = int'(bus.rsp_id);
          cap_hit   = int'(bus.rsp_hit);
          cap_ab    = int'(bus.rsp_abort);
          cap_count = int'(bus.rsp_count);
          cap_phigh = p_high;
          cap_cout  = int'(bus.c_out);
        end
      end else if (prev_rv) begin
        chk("grant_pulses", 32'(grants), 32'd1);
        void'(exp_q.pop_front());
        p_high = 0;
        grants = 0;
      end
      prev_rv = bus.rsp_valid;
    end
  end

  // ab_mode: 0 none, 1 abort in GRANT, 2 abort in LOAD, 3 abort on RUN edge ab_at.
  task automatic episode(input int z_at, input int ab_mode, input int ab_at,
                         input int bp, input int rst_at, input bit cont);
    exp_t e;
    int id, ev, run, resp, cyc;
    bit hit, ab, lp, done;
    id = rr_pick(bus.req_valid, m_ptr);
    if (id < 0) begin
      chk("episode_no_request", 32'd0, 32'd1);
      return;
    end
    ev = TIMEOUT; hit = 1'b0; ab = 1'b0;
    if (ab_mode == 1 || ab_mode == 2) begin
      ev = 0; ab = 1'b1;
    end else begin
      if (z_at > 0 && z_at <= ev) begin ev = z_at; hit = 1'b1; end
      if (ab_mode == 3 && ab_at > 0 && (ab_at < ev || (ab_at == ev && !hit))) begin
        ev = ab_at; ab = 1'b1; hit = 1'b0;
      end
    end
    e.id = id; e.hit = hit; e.ab = ab; e.count = ev; e.cmp = cmp_w[id];
    exp_q.push_back(e);
    run = 0; resp = 0; lp = 1'b0; done = 1'b0; cyc = 0;
    while (!done) begin
      @(negedge ck);
      cyc++;
      bus.z_in = 1'b0; bus.abort = 1'b0; bus.rsp_ready = 1'b0;
      if (cyc > TIMEOUT + 100) begin
        chk("episode_cycle_budget", 32'(cyc), 32'(TIMEOUT + 100));
        done = 1'b1;
      end else if (bus.req_ready != '0) begin
        if (!cont) bus.req_valid = bus.req_valid & ~(NREQ'(1) << id);
        bus.abort = (ab_mode == 1);
        lp = 1'b1;
      end else if (bus.rsp_valid) begin
        lp = 1'b0;
        resp++;
        if (resp > bp) bus.rsp_ready = 1'b1;
        else begin bus.abort = 1'b1; bus.z_in = 1'b1; end
      end else if (bus.p_0) begin
        run++;
        if (rst_at != 0 && run == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_async_p0", 32'(bus.p_0), 32'd0);
          chk("rst_async_rsp", 32'(bus.rsp_valid), 32'd0);
          exp_q.delete();
          m_ptr = 0;
          repeat (3) @(negedge ck);
          rst_n = 1'b1;
          done = 1'b1;
        end else begin
          bus.z_in  = (run == z_at);
          bus.abort = (ab_mode == 3 && run == ab_at);
        end
      end else if (lp) begin
        lp = 1'b0;
        bus.z_in  = 1'b1;
        bus.abort = (ab_mode == 2);
      end else if (resp > 0) begin
        m_ptr = (id + 1) % NREQ;
        done = 1'b1;
      end else begin
        bus.abort = 1'b1;
      end
    end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_cmp = '0; bus.abort = 1'b0;
    bus.z_in = 1'b0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) cmp_w[i] = '0;
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    repeat (50) @(negedge ck);

    // Single hit on 7th RUN edge.
    set_word(0, 17'h00005);
    bus.req_valid = 2'b01;
    episode(7, 0, 0, 0, 0, 1'b0);
    chk("lit_hit_id", 32'(cap_id), 32'd0);
    chk("lit_hit_hit", 32'(cap_hit), 32'd1);
    chk("lit_hit_abort", 32'(cap_ab), 32'd0);
    chk("lit_hit_count", 32'(cap_count), 32'd7);
    chk("lit_hit_p0", 32'(cap_phigh), 32'd7);
    chk("lit_hit_cout", 32'(cap_cout), 32'h00005);

    // Timeout from requester 1.
    set_word(1, 17'h1ABCD);
    bus.req_valid = 2'b10;
    episode(0, 0, 0, 2, 0, 1'b0);
    chk("lit_to_count", 32'(cap_count), 32'h03E8);
    chk("lit_to_hit", 32'(cap_hit), 32'd0);
    chk("lit_to_p0", 32'(cap_phigh), 32'd1000);

    // Match and abort on the same RUN edge: match wins.
    set_word(0, 17'h10001);
    bus.req_valid = 2'b01;
    episode(3, 3, 3, 0, 0, 1'b0);
    chk("lit_prio_hit", 32'(cap_hit), 32'd1);
    chk("lit_prio_abort", 32'(cap_ab), 32'd0);
    chk("lit_prio_count", 32'(cap_count), 32'd3);

    // Abort in LOAD; pointer is 1 so this also exercises the wrap to 0.
    set_word(0, 17'h0F0F0);
    bus.req_valid = 2'b01;
    episode(0, 2, 0, 1, 0, 1'b0);
    chk("lit_load_abort", 32'(cap_ab), 32'd1);
    chk("lit_load_count", 32'(cap_count), 32'd0);
    chk("lit_load_p0", 32'(cap_phigh), 32'd0);

    // Abort in GRANT.
    set_word(1, 17'h00F0F);
    bus.req_valid = 2'b10;
    episode(0, 1, 0, 0, 0, 1'b0);
    chk("lit_grant_abort", 32'(cap_ab), 32'd1);

    // Abort in RUN before a later match.
    set_word(0, 17'h12345);
    bus.req_valid = 2'b01;
    episode(9, 3, 5, 0, 0, 1'b0);
    chk("lit_run_abort_count", 32'(cap_count), 32'd5);

    // Hit on the very first RUN edge reports 1.
    bus.req_valid = 2'b10;
    episode(1, 0, 0, 0, 0, 1'b0);
    chk("lit_first_edge_count", 32'(cap_count), 32'd1);

    // Round-robin with both requesters always valid and 4-cycle backpressure.
    set_word(0, 17'h0AAAA);
    set_word(1, 17'h15555);
    bus.req_valid = 2'b11;
    episode(2, 0, 0, 4, 0, 1'b1);
    chk("lit_rr_0", 32'(cap_id), 32'd0);
    episode(4, 0, 0, 4, 0, 1'b1);
    chk("lit_rr_1", 32'(cap_id), 32'd1);
    episode(1, 0, 0, 4, 0, 1'b1);
    chk("lit_rr_2", 32'(cap_id), 32'd0);
    episode(3, 0, 0, 4, 0, 1'b1);
    bus.req_valid = 2'b00;
    chk("lit_rr_3", 32'(cap_id), 32'd1);
    repeat (3) @(negedge ck);

    // Move pointer to 1, then reset mid-RUN while serving requester 1.
    bus.req_valid = 2'b01;
    episode(2, 0, 0, 0, 0, 1'b0);
    bus.req_valid = 2'b10;
    episode(0, 0, 0, 0, 10, 1'b0);
    bus.req_valid = 2'b11;
    episode(2, 0, 0, 0, 0, 1'b0);
    chk("lit_post_rst_id", 32'(cap_id), 32'd0);
    episode(3, 0, 0, 0, 0, 1'b0);
    chk("lit_post_rst_id2", 32'(cap_id), 32'd1);

    repeat (5) @(negedge ck);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
